core_ras: RTL and testbench
===========================

Name: core_ras

Overview:
- Speculative return-address stack (RAS) in the branch prediction unit.
- Fetch-side predictor pushes on predicted calls and pops on predicted returns. Its top-of-stack supplies the predicted target for return-type branches.
- The current pointer is exported so the predictor can snapshot it into the per-branch prediction as ras_ptr.
- The branch-resolve stage sends back a correction carrying that ras_ptr. On a mispredict the stack pointer is rolled back and the true branch's own stack effect is re-applied.

Parameters:
- DEPTH, 8, number of stack entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; must equal the ras_ptr field width in bpu_predict_t/bpu_correct_t.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- f_valid_i  input  1  fetch-side operation valid this cycle
- f_push_i  input  1  predicted call: push f_pc_i+4
- f_pop_i  input  1  predicted return: pop
- f_pc_i  input  32  PC of the predicted call
- top_o  output  32  return target prediction = entry at pointer
- ptr_o  output  PTR_W  current pointer, snapshotted into bpu_predict_t.ras_ptr
- correct_valid_i  input  1  correction from the resolve stage is valid
- correct_i  input  bpu_correct_t  fields used: miss, pc, true_target_type, ras_ptr
- push_cnt_o, pop_cnt_o, recover_cnt_o  output  32  perf counters (see Optional Feature)

Behaviour:
- State: mem[DEPTH] of 32 bits, ptr of PTR_W bits. ptr indexes the current top entry.
- Reset (asynchronous, any cycle, including mid-recovery):
  - ptr=0, all mem entries=0, all counters=0.
  - Hence top_o=0 and ptr_o=0 after reset.
- Outputs: top_o=mem[ptr] and ptr_o=ptr, both combinational from registers. A fetch operation becomes visible on the next cycle only; there is no same-cycle bypass.
- target_type encoding, held in the shared package: 0 none, 1 call, 2 return, 3 immediate.
- Fetch operations apply only when f_valid_i=1 and no recovery is happening this cycle:
  - push only: ptr<=ptr+1; mem[ptr+1]<=f_pc_i+4.
  - pop only: ptr<=ptr-1; mem is unchanged.
  - push and pop together: mem[ptr]<=f_pc_i+4; ptr unchanged (replace top).
  - neither: no change.
- Recovery fires when correct_valid_i=1 and correct_i.miss=1. Let p=correct_i.ras_ptr, the pointer as it was before that branch's own stack operation.
  - true_target_type=call: ptr<=p+1; mem[p+1]<=correct_i.pc+4.
  - true_target_type=return: ptr<=p-1.
  - otherwise: ptr<=p.
- Priority: recovery overrides any same-cycle fetch operation, which is discarded. A correction with miss=0 changes nothing.
- Arithmetic: all pointer arithmetic is modulo DEPTH.
  - Overflow (more than DEPTH outstanding pushes) silently overwrites the oldest entry.
  - Underflow wraps the pointer; there is no empty flag and no error output.
- Entries are never cleared except by reset. Stale entries may be returned after underflow; this is acceptable as a prediction.
- The correction input is consumed in one cycle; there is no handshake or backpressure.

Optional Feature:
- Macro: CORE_RAS_PERF_EN.
- Defined: three 32-bit saturating counters.
  - push_cnt_o increments on each applied fetch push, including push+pop.
  - pop_cnt_o increments on each applied fetch pop, including push+pop.
  - recover_cnt_o increments on each recovery.
  - Discarded fetch operations (overridden by recovery) do not count.
  - Counters hold at 32'hFFFF_FFFF.
- Not defined: the counter registers are not built and the three outputs are tied to 0.

Decomposition:
- Shared package (pipeline.svh): target_type constants (_TARGET_NONE/_CALL/_RETURN/_IMM); the ras_ptr width constant shared by DEPTH, bpu_predict_t and bpu_correct_t; and bpu_correct_t itself.
- No sub-module. The optional counters are simple enough to stay inline under the `ifdef.

Test Plan:
- Reset, then push f_pc_i=32'h1000 and push 32'h2000 on consecutive cycles:
  - ptr_o=2, top_o=32'h2004.
  - Pop once: ptr_o=1, top_o=32'h1004.
- Push+pop together at ptr=1 with f_pc_i=32'h3000: ptr_o stays 1, top_o=32'h3004.
- Recovery with ras_ptr=1, true_target_type=call, pc=32'h4000, plus a simultaneous fetch push:
  - Next cycle ptr_o=2, top_o=32'h4004.
  - The fetch push is dropped; with CORE_RAS_PERF_EN, push_cnt_o is unchanged and recover_cnt_o increments by 1.
- DEPTH=8: 9 pushes of pcs 32'h100..32'h900:
  - ptr_o=1, top_o=32'h904.
  - mem[0] holds 32'h804; the oldest entry is overwritten.
- Correction valid with miss=0 and arbitrary ras_ptr: ptr_o and top_o are unchanged. Recovery with true_target_type=return and ras_ptr=0: ptr_o=7.
- Assert rst_n low mid-sequence at ptr=5: ptr_o=0 and top_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/core_ras_pkg.sv
// ----------------------------------------------------------------------------
// core_ras_pkg
// Shared branch-prediction types for the return-address stack and its users.
//   - target_type_e : encoding of a branch's target class
//                     (0 none, 1 call, 2 return, 3 immediate)
//   - RAS_DEPTH / RAS_PTR_W : stack depth and the ras_ptr field width shared
//                     by core_ras, bpu_predict_t and bpu_correct_t
//   - bpu_predict_t : per-branch prediction record (carries the ras_ptr snapshot)
//   - bpu_correct_t : resolve-stage correction sent back to the predictor
//   - ret_addr()    : return address of a call at a given PC
// ----------------------------------------------------------------------------
package core_ras_pkg;

    localparam int RAS_DEPTH = 8;
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);

    typedef enum logic [1:0] {
        TARGET_NONE   = 2'd0,
        TARGET_CALL   = 2'd1,
        TARGET_RETURN = 2'd2,
        TARGET_IMM    = 2'd3
    } target_type_e;

    typedef struct packed {
        logic                 valid;
        logic [31:0]          pc;
        logic [31:0]          target;
        target_type_e         target_type;
        logic [RAS_PTR_W-1:0] ras_ptr;
    } bpu_predict_t;

    // Only the fields the stack consumes are carried here.
    typedef struct packed {
        logic                 miss;
        logic [31:0]          pc;
        target_type_e         true_target_type;
        logic [RAS_PTR_W-1:0] ras_ptr;
    } bpu_correct_t;

    function automatic logic [31:0] ret_addr(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/core_ras.sv
// ----------------------------------------------------------------------------
// core_ras
// Speculative return-address stack for the branch prediction unit.
// Fetch pushes the return address of predicted calls and pops on predicted
// returns; the resolve stage rolls the pointer back on a mispredict and
// re-applies the true branch's own stack effect.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   f_valid_i               fetch-side operation valid
//   f_push_i / f_pop_i      predicted call / predicted return
//   f_pc_i                  PC of the predicted call
//   top_o                   predicted return target (entry at pointer)
//   ptr_o                   current pointer, snapshotted as ras_ptr
//   correct_valid_i         correction valid
//   correct_i               correction record (miss, pc, true_target_type, ras_ptr)
//   push_cnt_o, pop_cnt_o,
//   recover_cnt_o           saturating perf counters
//
// Configuration macro: CORE_RAS_PERF_EN builds the perf counters; without it
// the three counter outputs are tied to zero.
// ----------------------------------------------------------------------------
module core_ras
    import core_ras_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               f_valid_i,
    input  logic               f_push_i,
    input  logic               f_pop_i,
    input  logic [31:0]        f_pc_i,
    output logic [31:0]        top_o,
    output logic [PTR_W-1:0]   ptr_o,
    input  logic               correct_valid_i,
    input  bpu_correct_t       correct_i,
    output logic [31:0]        push_cnt_o,
    output logic [31:0]        pop_cnt_o,
    output logic [31:0]        recover_cnt_o
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [31:0]      mem_reg [DEPTH];
    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [31:0]      wr_data;

    logic             recover;
    logic             fetch_en;
    logic [PTR_W-1:0] rec_ptr;

    assign recover  = correct_valid_i && correct_i.miss;
    // A recovery in the same cycle discards the fetch operation entirely.
    assign fetch_en = f_valid_i && !recover;
    assign rec_ptr  = PTR_W'(correct_i.ras_ptr);

    // Next pointer and the single possible stack write for this cycle.
    // Pointer arithmetic wraps naturally at PTR_W bits (DEPTH is a power of
    // two), which gives the overwrite-oldest / wrap-on-underflow behaviour.
    always_comb begin
        ptr_next = ptr_reg;
        wr_en    = 1'b0;
        wr_idx   = ptr_reg;
        wr_data  = ret_addr(f_pc_i);
        if (recover) begin
            case (correct_i.true_target_type)
                TARGET_CALL: begin
                    ptr_next = rec_ptr + PTR_ONE;
                    wr_en    = 1'b1;
                    wr_idx   = rec_ptr + PTR_ONE;
                    wr_data  = ret_addr(correct_i.pc);
                end
                TARGET_RETURN: ptr_next = rec_ptr - PTR_ONE;
                default:       ptr_next = rec_ptr;
            endcase
        end else if (fetch_en) begin
            if (f_push_i && f_pop_i) begin
                // Call immediately after a return: replace the top in place.
                wr_en  = 1'b1;
                wr_idx = ptr_reg;
            end else if (f_push_i) begin
                ptr_next = ptr_reg + PTR_ONE;
                wr_en    = 1'b1;
                wr_idx   = ptr_reg + PTR_ONE;
            end else if (f_pop_i) begin
                ptr_next = ptr_reg - PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // Entries are cleared only by reset, so the stack lives in flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[wr_idx] <= wr_data;
        end
    end

    // No same-cycle bypass: outputs reflect registered state only.
    assign top_o = mem_reg[ptr_reg];
    assign ptr_o = ptr_reg;

`ifdef CORE_RAS_PERF_EN
    logic [31:0] push_cnt_reg;
    logic [31:0] pop_cnt_reg;
    logic [31:0] recover_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_cnt_reg    <= '0;
            pop_cnt_reg     <= '0;
            recover_cnt_reg <= '0;
        end else begin
            if (fetch_en && f_push_i && (push_cnt_reg != 32'hFFFF_FFFF)) begin
                push_cnt_reg <= push_cnt_reg + 32'd1;
            end
            if (fetch_en && f_pop_i && (pop_cnt_reg != 32'hFFFF_FFFF)) begin
                pop_cnt_reg <= pop_cnt_reg + 32'd1;
            end
            if (recover && (recover_cnt_reg != 32'hFFFF_FFFF)) begin
                recover_cnt_reg <= recover_cnt_reg + 32'd1;
            end
        end
    end

    assign push_cnt_o    = push_cnt_reg;
    assign pop_cnt_o     = pop_cnt_reg;
    assign recover_cnt_o = recover_cnt_reg;
`else
    assign push_cnt_o    = 32'd0;
    assign pop_cnt_o     = 32'd0;
    assign recover_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_core_ras.sv
// ----------------------------------------------------------------------------
// tb_core_ras
// Self-checking bench for core_ras (DEPTH = 8). Each driven transaction
// pushes the expected post-edge state onto a scoreboard queue; the entry is
// popped and compared one edge later. Counter expectations follow
// CORE_RAS_PERF_EN in the same way the design does.
// ----------------------------------------------------------------------------
module tb_core_ras;
    import core_ras_pkg::*;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic               clk;
    logic               rst_n;
    logic               f_valid_i;
    logic               f_push_i;
    logic               f_pop_i;
    logic [31:0]        f_pc_i;
    logic [31:0]        top_o;
    logic [PTR_W-1:0]   ptr_o;
    logic               correct_valid_i;
    bpu_correct_t       correct_i;
    logic [31:0]        push_cnt_o;
    logic [31:0]        pop_cnt_o;
    logic [31:0]        recover_cnt_o;

    core_ras #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .f_valid_i       (f_valid_i),
        .f_push_i        (f_push_i),
        .f_pop_i         (f_pop_i),
        .f_pc_i          (f_pc_i),
        .top_o           (top_o),
        .ptr_o           (ptr_o),
        .correct_valid_i (correct_valid_i),
        .correct_i       (correct_i),
        .push_cnt_o      (push_cnt_o),
        .pop_cnt_o       (pop_cnt_o),
        .recover_cnt_o   (recover_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PTR_W-1:0] ptr;
        logic [31:0]      top;
        logic [31:0]      push_cnt;
        logic [31:0]      pop_cnt;
        logic [31:0]      rec_cnt;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic [31:0]      m_mem [DEPTH];
    logic [PTR_W-1:0] m_ptr;
    logic [31:0]      m_push_cnt;
    logic [31:0]      m_pop_cnt;
    logic [31:0]      m_rec_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        m_ptr      = '0;
        m_push_cnt = 32'd0;
        m_pop_cnt  = 32'd0;
        m_rec_cnt  = 32'd0;
    endtask

    task automatic drive_idle();
        f_valid_i        = 1'b0;
        f_push_i         = 1'b0;
        f_pop_i          = 1'b0;
        f_pc_i           = 32'd0;
        correct_valid_i  = 1'b0;
        correct_i        = '0;
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input logic v, input logic push, input logic pop,
                        input logic [31:0] pc, input logic cv, input logic miss,
                        input logic [1:0] tt, input logic [PTR_W-1:0] rp,
                        input string name);
        exp_t e;
        exp_t o;
        logic [PTR_W-1:0] p;
        f_valid_i                   = v;
        f_push_i                    = push;
        f_pop_i                     = pop;
        f_pc_i                      = pc;
        correct_valid_i             = cv;
        correct_i.miss              = miss;
        correct_i.pc                = pc ^ 32'h0000_0000;
        correct_i.true_target_type  = target_type_e'(tt);
        correct_i.ras_ptr           = rp;

        if (cv && miss) begin
            p = rp;
            m_rec_cnt = m_rec_cnt + 32'd1;
            if (tt == 2'd1) begin
                m_ptr = p + 3'd1;
                m_mem[m_ptr] = pc + 32'd4;
            end else if (tt == 2'd2) begin
                m_ptr = p - 3'd1;
            end else begin
                m_ptr = p;
            end
        end else if (v) begin
            if (push) m_push_cnt = m_push_cnt + 32'd1;
            if (pop)  m_pop_cnt  = m_pop_cnt + 32'd1;
            if (push && pop) begin
                m_mem[m_ptr] = pc + 32'd4;
            end else if (push) begin
                m_ptr = m_ptr + 3'd1;
                m_mem[m_ptr] = pc + 32'd4;
            end else if (pop) begin
                m_ptr = m_ptr - 3'd1;
            end
        end

        e.ptr = m_ptr;
        e.top = m_mem[m_ptr];
`ifdef CORE_RAS_PERF_EN
        e.push_cnt = m_push_cnt;
        e.pop_cnt  = m_pop_cnt;
        e.rec_cnt  = m_rec_cnt;
`else
        e.push_cnt = 32'd0;
        e.pop_cnt  = 32'd0;
        e.rec_cnt  = 32'd0;
`endif
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        n_txn++;
        $display("txn %0d %s: v=%0b push=%0b pop=%0b pc=0x%08h cv=%0b miss=%0b tt=%0d rp=%0d -> ptr=%0d top=0x%08h",
                 n_txn, name, v, push, pop, pc, cv, miss, tt, rp, ptr_o, top_o);
        check_eq({name, "_ptr"}, 32'(ptr_o), 32'(o.ptr));
        check_eq({name, "_top"}, top_o, o.top);
        check_eq({name, "_push_cnt"}, push_cnt_o, o.push_cnt);
        check_eq({name, "_pop_cnt"}, pop_cnt_o, o.pop_cnt);
        check_eq({name, "_rec_cnt"}, recover_cnt_o, o.rec_cnt);
        drive_idle();
    endtask

    task automatic apply_reset();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        // Reset must act without a clock edge.
        check_eq("async_rst_ptr", 32'(ptr_o), 32'd0);
        check_eq("async_rst_top", top_o, 32'd0);
        check_eq("async_rst_push_cnt", push_cnt_o, 32'd0);
        check_eq("async_rst_rec_cnt", recover_cnt_o, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        drive_idle();
        model_reset();
        #2;
        apply_reset();

        // Two pushes, then a pop
        step(1, 1, 0, 32'h1000, 0, 0, 0, 0, "push1");
        step(1, 1, 0, 32'h2000, 0, 0, 0, 0, "push2");
        check_eq("plan_ptr2", 32'(ptr_o), 32'd2);
        check_eq("plan_top2004", top_o, 32'h2004);
        step(1, 0, 1, 32'h0, 0, 0, 0, 0, "pop1");
        check_eq("plan_ptr1", 32'(ptr_o), 32'd1);
        check_eq("plan_top1004", top_o, 32'h1004);

        // Push+pop replaces top
        step(1, 1, 1, 32'h3000, 0, 0, 0, 0, "pushpop");
        check_eq("plan_pp_top", top_o, 32'h3004);

        // Recovery as call overrides a simultaneous fetch push
        f_pc_i = 32'h4000;
        step(1, 1, 0, 32'h4000, 1, 1, 2'd1, 3'd1, "rec_call");
        check_eq("plan_rec_ptr", 32'(ptr_o), 32'd2);
        check_eq("plan_rec_top", top_o, 32'h4004);

        // Correction without miss changes nothing
        step(0, 0, 0, 32'h7777_0000, 1, 0, 2'd1, 3'd6, "corr_nomiss");
        // Return recovery from ras_ptr 0 wraps to 7
        step(0, 0, 0, 32'h0, 1, 1, 2'd2, 3'd0, "rec_ret_wrap");
        check_eq("plan_wrap_ptr", 32'(ptr_o), 32'd7);
        // Immediate-type recovery restores the snapshot
        step(0, 0, 0, 32'h0, 1, 1, 2'd3, 3'd4, "rec_imm");

        // Walk up to ptr 5 and reset mid-sequence
        step(1, 1, 0, 32'h5000, 0, 0, 0, 0, "push_to5");
        check_eq("plan_at5", 32'(ptr_o), 32'd5);
        apply_reset();

        // Overflow: 9 pushes on an 8-deep stack
        for (int i = 1; i <= 9; i++) begin
            step(1, 1, 0, 32'(i) << 8, 0, 0, 0, 0, "ovf_push");
        end
        check_eq("plan_ovf_ptr", 32'(ptr_o), 32'd1);
        check_eq("plan_ovf_top", top_o, 32'h904);
        step(1, 0, 1, 32'h0, 0, 0, 0, 0, "ovf_pop");
        check_eq("plan_ovf_mem0", top_o, 32'h804);

        // Random mix of fetch operations and corrections
        for (int i = 0; i < 300; i++) begin
            logic cv;
            cv = ($urandom_range(0, 3) == 0);
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom & 32'hFFFF_FFFC, cv, 1'($urandom),
                 2'($urandom), 3'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
